// File: rtl/enc32to5_req.sv
// Sequential 32-to-5 request encoder: latches request strobes and presents
// pending sources one at a time, lowest index first, over a valid/ack handshake.
module enc32to5_req #(
    parameter int unsigned N_REQ = 32,
    parameter int unsigned ADR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             clr,
    input  logic             ack,
    output logic [ADR_W-1:0] adr,
    output logic             valid,
    output logic [N_REQ-1:0] pending,
    output logic [ADR_W:0]   count,
    output logic             ovf
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e           state_q;
    logic [N_REQ-1:0] served;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] cand;
    logic             cand_any;
    logic [ADR_W-1:0] sel;
    logic [ADR_W:0]   count_d;
    logic             ovf_d;

    function automatic logic [ADR_W:0] popcount(input logic [N_REQ-1:0] v);
        logic [ADR_W:0] acc;
        acc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            acc = acc + (ADR_W+1)'(v[i]);
        end
        return acc;
    endfunction

    // Scan from the top so the lowest set bit is the last one written.
    function automatic logic [ADR_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
        logic [ADR_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ADR_W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        served = '0;
        if (valid && ack) begin
            served = N_REQ'(1) << adr;
        end

        // A request on the bit being served re-arms it rather than overflowing.
        if (clr) begin
            pending_d = '0;
            ovf_d     = 1'b0;
        end else begin
            pending_d = (pending & ~served) | req;
            ovf_d     = |(req & pending & ~served);
        end

        // Candidates come from the registered vector, so same-cycle requests wait a cycle.
        cand     = pending & mask & ~served;
        cand_any = |cand;
        sel      = lowest_set(cand);
        count_d  = popcount(pending_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            adr     <= '0;
            valid   <= 1'b0;
            pending <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= pending_d;
            count   <= count_d;
            ovf     <= ovf_d;
            if (clr) begin
                valid   <= 1'b0;
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cand_any) begin
                            adr     <= sel;
                            valid   <= 1'b1;
                            state_q <= StPresent;
                        end
                    end
                    StPresent: begin
                        // Presented index is frozen until the consumer takes it.
                        if (ack) begin
                            if (cand_any) begin
                                adr <= sel;
                            end else begin
                                valid   <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: begin
                        valid   <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enc32to5_req.sv
// Directed bench for enc32to5_req; expected outputs are queued with each
// stimulus step and checked one cycle later.
module tb_enc32to5_req;

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    typedef struct {
        logic        valid;
        logic        chk_adr;
        logic [4:0]  adr;
        logic [31:0] pending;
        logic [5:0]  count;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic [31:0] mask;
    logic        clr;
    logic        ack;
    logic [4:0]  adr;
    logic        valid;
    logic [31:0] pending;
    logic [5:0]  count;
    logic        ovf;

    exp_t  sb[$];
    string tq[$];
    int    vectors;
    int    miscompares;

    enc32to5_req #(
        .N_REQ(32),
        .ADR_W(5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .mask   (mask),
        .clr    (clr),
        .ack    (ack),
        .adr    (adr),
        .valid  (valid),
        .pending(pending),
        .count  (count),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [4:0] a, input logic [31:0] p,
                                input logic [5:0] c, input logic o);
        exp_t e;
        e.valid   = v;
        e.chk_adr = v;
        e.adr     = a;
        e.pending = p;
        e.count   = c;
        e.ovf     = o;
        return e;
    endfunction

    task automatic check_out();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = tq.pop_front();
        vectors++;
        assert (valid === e.valid) else begin
            miscompares++;
            $error("FAIL %s valid got %0b want %0b", t, valid, e.valid);
        end
        if (e.chk_adr) begin
            assert (adr === e.adr) else begin
                miscompares++;
                $error("FAIL %s adr got %0d want %0d", t, adr, e.adr);
            end
        end
        assert (pending === e.pending) else begin
            miscompares++;
            $error("FAIL %s pending got %h want %h", t, pending, e.pending);
        end
        assert (count === e.count) else begin
            miscompares++;
            $error("FAIL %s count got %0d want %0d", t, count, e.count);
        end
        assert (ovf === e.ovf) else begin
            miscompares++;
            $error("FAIL %s ovf got %0b want %0b", t, ovf, e.ovf);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, check after the edge.
    task automatic step(input logic [31:0] r, input logic [31:0] m, input logic c,
                        input logic a, input exp_t e, input string t);
        req  = r;
        mask = m;
        clr  = c;
        ack  = a;
        sb.push_back(e);
        tq.push_back(t);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_reset(input string t);
        exp_t e;
        e = mk(1'b0, 5'd0, 32'h0, 6'd0, 1'b0);
        e.chk_adr = 1'b1;
        sb.push_back(e);
        tq.push_back(t);
        check_out();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req   = '0;
        mask  = ALL;
        clr   = 1'b0;
        ack   = 1'b0;
        #2;
        check_reset("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request, present, ack
        step(32'h8, ALL, 0, 0, mk(0, 0, 32'h8, 1, 0), "t1_req");
        step(32'h0, ALL, 0, 0, mk(1, 3, 32'h8, 1, 0), "t1_present");
        step(32'h0, ALL, 0, 1, mk(0, 0, 32'h0, 0, 0), "t1_ack");

        // Back-to-back service with ack held high
        step(32'h8000_0011, ALL, 0, 1, mk(0, 0, 32'h8000_0011, 3, 0), "t2_req");
        step(32'h0, ALL, 0, 1, mk(1, 0, 32'h8000_0011, 3, 0), "t2_adr0");
        step(32'h0, ALL, 0, 1, mk(1, 4, 32'h8000_0010, 2, 0), "t2_adr4");
        step(32'h0, ALL, 0, 1, mk(1, 31, 32'h8000_0000, 1, 0), "t2_adr31");
        step(32'h0, ALL, 0, 1, mk(0, 0, 32'h0, 0, 0), "t2_done");

        // Masked bit stays pending until unmasked
        step(32'h3, 32'hFFFF_FFFE, 0, 0, mk(0, 0, 32'h3, 2, 0), "t3_req");
        step(32'h0, 32'hFFFF_FFFE, 0, 0, mk(1, 1, 32'h3, 2, 0), "t3_adr1");
        step(32'h0, 32'hFFFF_FFFE, 0, 1, mk(0, 0, 32'h1, 1, 0), "t3_ack1");
        step(32'h0, 32'hFFFF_FFFE, 0, 0, mk(0, 0, 32'h1, 1, 0), "t3_masked");
        step(32'h0, ALL, 0, 0, mk(1, 0, 32'h1, 1, 0), "t3_unmask");
        step(32'h0, ALL, 0, 1, mk(0, 0, 32'h0, 0, 0), "t3_ack0");

        // Presented index held against lower requests and masking; overflow pulse
        step(32'h20, ALL, 0, 0, mk(0, 0, 32'h20, 1, 0), "t4_req5");
        step(32'h0, ALL, 0, 0, mk(1, 5, 32'h20, 1, 0), "t4_adr5");
        step(32'h1, ALL, 0, 0, mk(1, 5, 32'h21, 2, 0), "t4_req0_hold");
        step(32'h0, 32'hFFFF_FFDF, 0, 0, mk(1, 5, 32'h21, 2, 0), "t4_mask_hold");
        step(32'h20, ALL, 0, 0, mk(1, 5, 32'h21, 2, 1), "t4_ovf");
        step(32'h0, ALL, 0, 0, mk(1, 5, 32'h21, 2, 0), "t4_ovf_end");
        step(32'h0, ALL, 0, 1, mk(1, 0, 32'h1, 1, 0), "t4_ack5");
        step(32'h0, ALL, 0, 1, mk(0, 0, 32'h0, 0, 0), "t4_ack0");

        // Req on the bit being served re-arms it without overflow; then flush
        step(32'h80, ALL, 0, 0, mk(0, 0, 32'h80, 1, 0), "t5_req7");
        step(32'h0, ALL, 0, 0, mk(1, 7, 32'h80, 1, 0), "t5_adr7");
        step(32'h80, ALL, 0, 1, mk(0, 0, 32'h80, 1, 0), "t5_rearm");
        step(32'h0, ALL, 0, 0, mk(1, 7, 32'h80, 1, 0), "t5_again7");
        step(ALL, ALL, 1, 0, mk(0, 0, 32'h0, 0, 0), "t5_clr");

        // Full vector, then asynchronous reset mid-stream
        step(ALL, ALL, 0, 0, mk(0, 0, ALL, 32, 0), "t6_all");
        step(32'h0, ALL, 0, 0, mk(1, 0, ALL, 32, 0), "t6_adr0");
        step(ALL, ALL, 0, 0, mk(1, 0, ALL, 32, 1), "t6_ovf");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("t6_async_rst");
        req   = '0;
        rst_n = 1'b1;
        step(32'h4, ALL, 0, 0, mk(0, 0, 32'h4, 1, 0), "t6_recover");
        step(32'h0, ALL, 0, 0, mk(1, 2, 32'h4, 1, 0), "t6_recover_adr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
